// File: rtl/usb_pkt_rx_if.sv
// Received byte stream from the ULPI link controller plus decoded packet results.
// The parser connects through the slave modport; the link/transaction side uses master.
interface usb_pkt_rx_if;
    logic [7:0]  RX_DATA;
    logic        RX_STRB;
    logic        RX_END;
    logic        RX_FAIL;

    logic        TOKEN_VALID;
    logic [3:0]  TOKEN_PID;
    logic [6:0]  TOKEN_ADDR;
    logic [3:0]  TOKEN_ENDP;
    logic        SOF_VALID;
    logic [10:0] SOF_FRAME;
    logic        HS_VALID;
    logic [3:0]  HS_PID;
    logic        DATA_START;
    logic [3:0]  DATA_PID;
    logic [7:0]  DATA_BYTE;
    logic        DATA_STRB;
    logic [10:0] DATA_LEN;
    logic        DATA_DONE;
    logic        RX_ERR;

    modport master (
        output RX_DATA, RX_STRB, RX_END, RX_FAIL,
        input  TOKEN_VALID, TOKEN_PID, TOKEN_ADDR, TOKEN_ENDP,
        input  SOF_VALID, SOF_FRAME, HS_VALID, HS_PID,
        input  DATA_START, DATA_PID, DATA_BYTE, DATA_STRB, DATA_LEN, DATA_DONE,
        input  RX_ERR
    );

    modport slave (
        input  RX_DATA, RX_STRB, RX_END, RX_FAIL,
        output TOKEN_VALID, TOKEN_PID, TOKEN_ADDR, TOKEN_ENDP,
        output SOF_VALID, SOF_FRAME, HS_VALID, HS_PID,
        output DATA_START, DATA_PID, DATA_BYTE, DATA_STRB, DATA_LEN, DATA_DONE,
        output RX_ERR
    );
endinterface

// File: rtl/usb_pkt_rx.sv
// USB receive packet parser: PID/length/CRC checking and decode of token, SOF,
// handshake and data packets from the link controller byte stream.
//
// state   | meaning
// IDLE    | waiting for a PID byte
// TOK1    | token/SOF, expecting first field byte
// TOK2    | token/SOF, expecting second field byte
// TOK_END | token complete, waiting for end of packet
// HS_END  | handshake PID seen, waiting for end of packet
// DATA    | data payload + CRC16 bytes streaming in
// DISCARD | bad/unsupported packet, dropping bytes until end
module usb_pkt_rx #(
    parameter int MAX_PAYLOAD = 1024
) (
    input  logic         CLK_60M,
    input  logic         NRST_A_USB,
    input  logic [6:0]   DEV_ADDR,
    usb_pkt_rx_if.slave  rx
);
    typedef enum logic [2:0] {
        IDLE, TOK1, TOK2, TOK_END, HS_END, DATA, DISCARD
    } state_t;

    localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
    localparam logic [4:0]  CRC5_RES = 5'h06;
    localparam logic [15:0] CRC16_RES = 16'hB001;

    state_t      state;
    logic [3:0]  pid_q;
    logic [7:0]  tok_b1;
    logic [7:0]  tok_b2;
    logic [7:0]  skid0;
    logic [7:0]  skid1;
    logic [1:0]  skid_cnt;
    logic [15:0] crc16;
    logic        err_pending;

    function automatic logic [4:0] crc5_run(input logic [15:0] bits);
        logic [4:0] r;
        r = 5'h1F;
        for (int i = 0; i < 16; i++) begin
            if (r[0] ^ bits[i]) r = (r >> 1) ^ 5'h14;
            else                r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            state          <= IDLE;
            pid_q          <= '0;
            tok_b1         <= '0;
            tok_b2         <= '0;
            skid0          <= '0;
            skid1          <= '0;
            skid_cnt       <= '0;
            crc16          <= '0;
            err_pending    <= 1'b0;
            rx.TOKEN_VALID <= 1'b0;
            rx.TOKEN_PID   <= '0;
            rx.TOKEN_ADDR  <= '0;
            rx.TOKEN_ENDP  <= '0;
            rx.SOF_VALID   <= 1'b0;
            rx.SOF_FRAME   <= '0;
            rx.HS_VALID    <= 1'b0;
            rx.HS_PID      <= '0;
            rx.DATA_START  <= 1'b0;
            rx.DATA_PID    <= '0;
            rx.DATA_BYTE   <= '0;
            rx.DATA_STRB   <= 1'b0;
            rx.DATA_LEN    <= '0;
            rx.DATA_DONE   <= 1'b0;
            rx.RX_ERR      <= 1'b0;
        end else begin
            rx.TOKEN_VALID <= 1'b0;
            rx.SOF_VALID   <= 1'b0;
            rx.HS_VALID    <= 1'b0;
            rx.DATA_START  <= 1'b0;
            rx.DATA_STRB   <= 1'b0;
            rx.DATA_DONE   <= 1'b0;
            rx.RX_ERR      <= 1'b0;

            // A link abort wins over everything; DISCARD only reports if not already reported.
            if (rx.RX_FAIL && state != IDLE) begin
                rx.RX_ERR   <= (state != DISCARD) || err_pending;
                state       <= IDLE;
                skid_cnt    <= '0;
                err_pending <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx.RX_STRB) begin
                            pid_q <= rx.RX_DATA[3:0];
                            if (rx.RX_DATA[7:4] != ~rx.RX_DATA[3:0]) begin
                                rx.RX_ERR   <= 1'b1;
                                err_pending <= 1'b0;
                                state       <= DISCARD;
                            end else begin
                                case (rx.RX_DATA[1:0])
                                    2'b01: state <= TOK1;
                                    2'b10: state <= HS_END;
                                    2'b11: begin
                                        state         <= DATA;
                                        rx.DATA_START <= 1'b1;
                                        rx.DATA_PID   <= rx.RX_DATA[3:0];
                                        rx.DATA_LEN   <= '0;
                                        crc16         <= 16'hFFFF;
                                        skid_cnt      <= '0;
                                    end
                                    default: begin
                                        err_pending <= 1'b1;
                                        state       <= DISCARD;
                                    end
                                endcase
                            end
                        end
                    end

                    TOK1: begin
                        if (rx.RX_STRB) begin
                            tok_b1 <= rx.RX_DATA;
                            state  <= TOK2;
                        end else if (rx.RX_END) begin
                            rx.RX_ERR <= 1'b1;
                            state     <= IDLE;
                        end
                    end

                    TOK2: begin
                        if (rx.RX_STRB) begin
                            tok_b2 <= rx.RX_DATA;
                            state  <= TOK_END;
                        end else if (rx.RX_END) begin
                            rx.RX_ERR <= 1'b1;
                            state     <= IDLE;
                        end
                    end

                    TOK_END: begin
                        if (rx.RX_STRB) begin
                            rx.RX_ERR   <= 1'b1;
                            err_pending <= 1'b0;
                            state       <= DISCARD;
                        end else if (rx.RX_END) begin
                            state <= IDLE;
                            if (crc5_run({tok_b2, tok_b1}) != CRC5_RES) begin
                                rx.RX_ERR <= 1'b1;
                            end else if (pid_q == 4'h5) begin
                                rx.SOF_VALID <= 1'b1;
                                rx.SOF_FRAME <= {tok_b2[2:0], tok_b1};
                            end else if (tok_b1[6:0] == DEV_ADDR) begin
                                rx.TOKEN_VALID <= 1'b1;
                                rx.TOKEN_PID   <= pid_q;
                                rx.TOKEN_ADDR  <= tok_b1[6:0];
                                rx.TOKEN_ENDP  <= {tok_b2[2:0], tok_b1[7]};
                            end
                        end
                    end

                    HS_END: begin
                        if (rx.RX_STRB) begin
                            rx.RX_ERR   <= 1'b1;
                            err_pending <= 1'b0;
                            state       <= DISCARD;
                        end else if (rx.RX_END) begin
                            rx.HS_VALID <= 1'b1;
                            rx.HS_PID   <= pid_q;
                            state       <= IDLE;
                        end
                    end

                    DATA: begin
                        if (rx.RX_STRB) begin
                            crc16 <= crc16_byte(crc16, rx.RX_DATA);
                            // Two bytes are always held back so the CRC16 bytes never reach the output.
                            if (skid_cnt == 2'd2) begin
                                if (rx.DATA_LEN == MAX_LEN) begin
                                    rx.RX_ERR   <= 1'b1;
                                    err_pending <= 1'b0;
                                    skid_cnt    <= '0;
                                    state       <= DISCARD;
                                end else begin
                                    rx.DATA_BYTE <= skid0;
                                    rx.DATA_STRB <= 1'b1;
                                    rx.DATA_LEN  <= rx.DATA_LEN + 11'd1;
                                    skid0        <= skid1;
                                    skid1        <= rx.RX_DATA;
                                end
                            end else begin
                                if (skid_cnt == 2'd0) skid0 <= rx.RX_DATA;
                                else                  skid1 <= rx.RX_DATA;
                                skid_cnt <= skid_cnt + 2'd1;
                            end
                        end else if (rx.RX_END) begin
                            if (skid_cnt == 2'd2 && crc16 == CRC16_RES) rx.DATA_DONE <= 1'b1;
                            else                                        rx.RX_ERR    <= 1'b1;
                            skid_cnt <= '0;
                            state    <= IDLE;
                        end
                    end

                    DISCARD: begin
                        if (rx.RX_END) begin
                            rx.RX_ERR   <= err_pending;
                            err_pending <= 1'b0;
                            state       <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_pkt_rx.sv
// Directed bench for usb_pkt_rx: hand-built packets with expected pulse counts,
// captured payload bytes and field values.
module tb_usb_pkt_rx;
    logic       clk;
    logic       nrst;
    logic [6:0] dev_addr;

    usb_pkt_rx_if u_if();

    usb_pkt_rx #(.MAX_PAYLOAD(1024)) dut (
        .CLK_60M    (clk),
        .NRST_A_USB (nrst),
        .DEV_ADDR   (dev_addr),
        .rx         (u_if)
    );

    initial clk = 1'b0;
    always #8 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int n_tok = 0, n_sof = 0, n_hs = 0, n_start = 0, n_done = 0, n_err = 0, n_cap = 0;
    logic [7:0] cap [0:63];

    always @(negedge clk) begin
        if (u_if.TOKEN_VALID) n_tok   <= n_tok + 1;
        if (u_if.SOF_VALID)   n_sof   <= n_sof + 1;
        if (u_if.HS_VALID)    n_hs    <= n_hs + 1;
        if (u_if.DATA_START)  n_start <= n_start + 1;
        if (u_if.DATA_DONE)   n_done  <= n_done + 1;
        if (u_if.RX_ERR)      n_err   <= n_err + 1;
        if (u_if.DATA_STRB) begin
            cap[n_cap % 64] <= u_if.DATA_BYTE;
            n_cap           <= n_cap + 1;
        end
    end

    logic [59:0] all_outs;
    assign all_outs = {u_if.TOKEN_VALID, u_if.TOKEN_PID, u_if.TOKEN_ADDR, u_if.TOKEN_ENDP,
                       u_if.SOF_VALID, u_if.SOF_FRAME, u_if.HS_VALID, u_if.HS_PID,
                       u_if.DATA_START, u_if.DATA_PID, u_if.DATA_BYTE, u_if.DATA_STRB,
                       u_if.DATA_LEN, u_if.DATA_DONE, u_if.RX_ERR};

    int b_tok, b_sof, b_hs, b_start, b_done, b_err, b_cap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic snap();
        b_tok = n_tok; b_sof = n_sof; b_hs = n_hs; b_start = n_start;
        b_done = n_done; b_err = n_err; b_cap = n_cap;
    endtask

    task automatic send(input logic [7:0] b);
        u_if.RX_DATA = b;
        u_if.RX_STRB = 1'b1;
        @(negedge clk);
        u_if.RX_STRB = 1'b0;
    endtask

    task automatic pkt_end();
        u_if.RX_END = 1'b1;
        @(negedge clk);
        u_if.RX_END = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] setup_pl [0:7];

    initial begin
        setup_pl = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        nrst = 1'b0;
        dev_addr = 7'd0;
        u_if.RX_DATA = 8'h00;
        u_if.RX_STRB = 1'b0;
        u_if.RX_END  = 1'b0;
        u_if.RX_FAIL = 1'b0;
        gap(3);
        chk("reset_outputs", 64'(all_outs), 64'h0);
        nrst = 1'b1;
        gap(2);

        // SETUP to address 0, endpoint 0
        snap();
        send(8'h2D); send(8'h00); send(8'h10); pkt_end(); gap(2);
        chk("setup_valid", 64'(n_tok - b_tok), 64'd1);
        chk("setup_pid", 64'(u_if.TOKEN_PID), 64'hD);
        chk("setup_addr", 64'(u_if.TOKEN_ADDR), 64'h0);
        chk("setup_endp", 64'(u_if.TOKEN_ENDP), 64'h0);
        chk("setup_err", 64'(n_err - b_err), 64'd0);

        // same token, other device: silently dropped
        dev_addr = 7'd5;
        snap();
        send(8'h2D); send(8'h00); send(8'h10); pkt_end(); gap(2);
        chk("filter_valid", 64'(n_tok - b_tok), 64'd0);
        chk("filter_err", 64'(n_err - b_err), 64'd0);
        dev_addr = 7'd0;

        // corrupted CRC5
        snap();
        send(8'h2D); send(8'h00); send(8'h18); pkt_end(); gap(2);
        chk("crc5_bad_err", 64'(n_err - b_err), 64'd1);
        chk("crc5_bad_valid", 64'(n_tok - b_tok), 64'd0);

        // short token
        snap();
        send(8'h2D); send(8'h00); pkt_end(); gap(2);
        chk("short_tok_err", 64'(n_err - b_err), 64'd1);

        // DATA0 with 8-byte payload and good CRC16
        snap();
        send(8'hC3);
        for (int i = 0; i < 8; i++) send(setup_pl[i]);
        send(8'hDD); send(8'h94); pkt_end(); gap(2);
        chk("d0_start", 64'(n_start - b_start), 64'd1);
        chk("d0_pid", 64'(u_if.DATA_PID), 64'h3);
        chk("d0_strb_count", 64'(n_cap - b_cap), 64'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("d0_byte%0d", i), 64'(cap[(b_cap + i) % 64]), 64'(setup_pl[i]));
        chk("d0_done", 64'(n_done - b_done), 64'd1);
        chk("d0_len", 64'(u_if.DATA_LEN), 64'd8);
        chk("d0_err", 64'(n_err - b_err), 64'd0);

        // same packet, last CRC byte corrupted
        snap();
        send(8'hC3);
        for (int i = 0; i < 8; i++) send(setup_pl[i]);
        send(8'hDD); send(8'h95); pkt_end(); gap(2);
        chk("d0_bad_done", 64'(n_done - b_done), 64'd0);
        chk("d0_bad_err", 64'(n_err - b_err), 64'd1);

        // zero-length DATA1
        snap();
        send(8'h4B); send(8'h00); send(8'h00); pkt_end(); gap(2);
        chk("zlp_start", 64'(n_start - b_start), 64'd1);
        chk("zlp_pid", 64'(u_if.DATA_PID), 64'hB);
        chk("zlp_strb", 64'(n_cap - b_cap), 64'd0);
        chk("zlp_done", 64'(n_done - b_done), 64'd1);
        chk("zlp_len", 64'(u_if.DATA_LEN), 64'd0);

        // ACK then NAK back to back
        snap();
        send(8'hD2); pkt_end(); send(8'h5A); pkt_end(); gap(2);
        chk("hs_b2b_count", 64'(n_hs - b_hs), 64'd2);
        chk("hs_b2b_pid", 64'(u_if.HS_PID), 64'hA);
        chk("hs_b2b_err", 64'(n_err - b_err), 64'd0);

        // handshake with trailing byte
        snap();
        send(8'hD2); send(8'h00); pkt_end(); gap(2);
        chk("hs_long_err", 64'(n_err - b_err), 64'd1);
        chk("hs_long_valid", 64'(n_hs - b_hs), 64'd0);

        // bad PID: exactly one error
        snap();
        send(8'hD3); send(8'h11); pkt_end(); gap(3);
        chk("badpid_err", 64'(n_err - b_err), 64'd1);
        chk("badpid_start", 64'(n_start - b_start), 64'd0);

        // unsupported PING PID: one error at end
        snap();
        send(8'hB4); send(8'h00); send(8'h10); pkt_end(); gap(2);
        chk("ping_err", 64'(n_err - b_err), 64'd1);

        // link abort after the 4th payload byte
        snap();
        send(8'hC3);
        for (int i = 0; i < 4; i++) send(setup_pl[i]);
        u_if.RX_FAIL = 1'b1;
        @(negedge clk);
        u_if.RX_FAIL = 1'b0;
        chk("fail_err_next", 64'(u_if.RX_ERR), 64'd1);
        gap(2);
        chk("fail_err_count", 64'(n_err - b_err), 64'd1);
        chk("fail_done", 64'(n_done - b_done), 64'd0);
        chk("fail_strb_count", 64'(n_cap - b_cap), 64'd2);
        snap();
        send(8'hD2); pkt_end(); gap(2);
        chk("after_fail_hs", 64'(n_hs - b_hs), 64'd1);
        chk("after_fail_pid", 64'(u_if.HS_PID), 64'h2);

        // async reset in the middle of a token
        send(8'h2D); send(8'h00);
        #3 nrst = 1'b0;
        #1 chk("midreset_outputs", 64'(all_outs), 64'h0);
        gap(2);
        nrst = 1'b1;
        gap(1);

        // SOF frame 1
        snap();
        send(8'hA5); send(8'h01); send(8'hE8); pkt_end(); gap(2);
        chk("sof_valid", 64'(n_sof - b_sof), 64'd1);
        chk("sof_frame", 64'(u_if.SOF_FRAME), 64'h001);
        chk("sof_err", 64'(n_err - b_err), 64'd0);
        chk("sof_no_token", 64'(n_tok - b_tok), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
